// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, access sizes, fault causes.
// Also holds the request latch layout and the alignment rule.
package lsu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RD_W     = 5;
  localparam int unsigned CNT_W    = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_MEM   = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_ILL   = 2'b11;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_SECURE   = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  typedef struct packed {
    logic            load;
    logic [1:0]      size;
    logic            uns;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [RD_W-1:0] rd;
    logic            key;
  } lsu_req_t;

  // Illegal size code or an address not aligned to the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, memory-port and writeback signals of the load/store unit.
// slave = the LSU's view, master = the surrounding pipeline/memory view.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        key_access;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        done;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;
  logic [1:0]  fault_cause;

  modport slave (
    input  req_valid, req_load, req_size, req_unsigned, req_addr, req_wdata, req_rd,
           key_access, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           done, wb_valid, wb_rd, wb_data, fault, fault_cause
  );

  modport master (
    output req_valid, req_load, req_size, req_unsigned, req_addr, req_wdata, req_rd,
           key_access, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           done, wb_valid, wb_rd, wb_data, fault, fault_cause
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store strobes/replication and load lane extract with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            uns,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wstrb_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [XLEN-1:0] rdata_c
);

  logic [XLEN-1:0] rshift;

  always_comb begin
    wstrb_c = 4'h0;
    wdata_c = wdata;
    case (size)
      SZ_BYTE: begin
        wstrb_c = 4'b0001 << addr_lo;
        wdata_c = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        wstrb_c = 4'b0011 << addr_lo;
        wdata_c = {2{wdata[15:0]}};
      end
      SZ_WORD: wstrb_c = 4'hF;
      default: wstrb_c = 4'h0;
    endcase
  end

  // Move the addressed lane down to bit 0, then extend.
  always_comb begin
    rshift  = rdata >> {addr_lo, 3'b000};
    rdata_c = rdata;
    case (size)
      SZ_BYTE: rdata_c = uns ? {24'h0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
      SZ_HALF: rdata_c = uns ? {16'h0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      default: rdata_c = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage with secured-region check and memory timeout.
// Optional LSU_SEC_AUDIT_EN adds fault_addr and sec_viol_cnt outputs.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] SEC_BASE  = 32'h0000_F000,
  parameter logic [31:0] SEC_LIMIT = 32'h0000_FFFF,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  lsu_if.slave        bus
`ifdef LSU_SEC_AUDIT_EN
  ,
  output logic [31:0] fault_addr,
  output logic [7:0]  sec_viol_cnt
`endif
);

  logic [1:0]       state_q, state_d;
  lsu_req_t         req_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       chk_cause;
  logic [1:0]       cause_d;
  logic             wb_valid_d;
  logic [3:0]       wstrb_c;
  logic [XLEN-1:0]  wdata_c;
  logic [XLEN-1:0]  rdata_c;

  lsu_lane_align u_align (
    .addr_lo (req_q.addr[1:0]),
    .size    (req_q.size),
    .uns     (req_q.uns),
    .wdata   (req_q.wdata),
    .rdata   (bus.mem_rdata),
    .wstrb_c (wstrb_c),
    .wdata_c (wdata_c),
    .rdata_c (rdata_c)
  );

  // Alignment outranks the security check.
  always_comb begin
    chk_cause = FC_NONE;
    if (misaligned(req_q.size, req_q.addr[1:0])) begin
      chk_cause = FC_MISALIGN;
    end else if ((req_q.addr >= SEC_BASE) && (req_q.addr <= SEC_LIMIT) && !req_q.key) begin
      chk_cause = FC_SECURE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus the response qualifiers registered on entry to RESP.
  always_comb begin
    state_d    = state_q;
    cause_d    = FC_NONE;
    wb_valid_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (bus.req_valid) state_d = ST_CHECK;
      ST_CHECK: begin
        cause_d = chk_cause;
        state_d = (chk_cause != FC_NONE) ? ST_RESP : ST_MEM;
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          state_d    = ST_RESP;
          wb_valid_d = req_q.load && (req_q.rd != '0);
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_RESP;
          cause_d = FC_TIMEOUT;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
      cnt_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && bus.req_valid) begin
        req_q.load  <= bus.req_load;
        req_q.size  <= bus.req_size;
        req_q.uns   <= bus.req_unsigned;
        req_q.addr  <= bus.req_addr;
        req_q.wdata <= bus.req_wdata;
        req_q.rd    <= bus.req_rd;
        req_q.key   <= bus.key_access;
      end
      cnt_q <= ((state_q == ST_MEM) && (state_d == ST_MEM)) ? cnt_q + CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.req_ready   <= 1'b1;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_wstrb   <= '0;
      bus.done        <= 1'b0;
      bus.fault       <= 1'b0;
      bus.fault_cause <= FC_NONE;
      bus.wb_valid    <= 1'b0;
      bus.wb_rd       <= '0;
      bus.wb_data     <= '0;
    end else begin
      bus.req_ready   <= (state_d == ST_IDLE);
      bus.mem_req     <= (state_d == ST_MEM);
      bus.done        <= (state_d == ST_RESP);
      bus.fault       <= (cause_d != FC_NONE);
      bus.fault_cause <= cause_d;
      bus.wb_valid    <= wb_valid_d;
      // Memory port is loaded once on entry to MEM and held until the access ends.
      if ((state_q == ST_CHECK) && (state_d == ST_MEM)) begin
        bus.mem_we    <= !req_q.load;
        bus.mem_addr  <= {req_q.addr[31:2], 2'b00};
        bus.mem_wdata <= wdata_c;
        bus.mem_wstrb <= req_q.load ? 4'h0 : wstrb_c;
      end
      if (wb_valid_d) begin
        bus.wb_rd   <= req_q.rd;
        bus.wb_data <= rdata_c;
      end
    end
  end

`ifdef LSU_SEC_AUDIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_addr   <= '0;
      sec_viol_cnt <= '0;
    end else begin
      if (cause_d != FC_NONE) fault_addr <= req_q.addr;
      if ((cause_d == FC_SECURE) && (sec_viol_cnt != 8'hFF)) sec_viol_cnt <= sec_viol_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: transaction-level model, per-cycle compare, literal pins.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned TO = 16;
  localparam logic [31:0] SB = 32'h0000_F000;
  localparam logic [31:0] SL = 32'h0000_FFFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_if bus();
`ifdef LSU_SEC_AUDIT_EN
  logic [31:0] fault_addr;
  logic [7:0]  sec_viol_cnt;
`endif

  load_store_unit #(.SEC_BASE(SB), .SEC_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef LSU_SEC_AUDIT_EN
    ,
    .fault_addr   (fault_addr),
    .sec_viol_cnt (sec_viol_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the current transaction, relative to its accept cycle.
  int          t_acc    = -100000;
  int          done_rel = 0;
  int          mem_n    = 0;
  logic        in_rst   = 1'b1;
  logic        e_chkflt = 1'b0;
  logic [1:0]  e_cause  = 2'b00;
  logic        e_load   = 1'b0;
  logic        e_wb     = 1'b0;
  logic [4:0]  e_rd     = '0;
  logic [31:0] e_wbdata = '0;
  logic [31:0] e_maddr  = '0;
  logic [31:0] e_mwdata = '0;
  logic [3:0]  e_mstrb  = '0;
  logic [4:0]  held_rd  = '0;
  logic [31:0] held_data = '0;

  int          obs_done_rel;
  int          obs_mreq_n;
  logic [1:0]  obs_cause;
  logic [31:0] obs_maddr, obs_mwdata, obs_wbdata;
  logic [3:0]  obs_mstrb;
  logic        obs_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [1:0] m_cause(input logic [1:0] size, input logic [31:0] addr, input logic key);
    if (size == 2'b11 || (addr % nbytes(size)) != 0) return 2'b01;
    if (addr >= SB && addr <= SL && !key) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] rdata);
    int nb = nbytes(size);
    logic [31:0] v, mask;
    v = rdata >> (8 * addr[1:0]);
    if (nb < 4) begin
      mask = (32'h1 << (8 * nb)) - 32'h1;
      v = v & mask;
      if (!uns && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] size, input logic [31:0] addr);
    logic [3:0] s = '0;
    for (int i = 0; i < 4; i++) s[i] = (i >= addr[1:0]) && (i < addr[1:0] + nbytes(size));
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(size)) +: 8];
    return r;
  endfunction

  // Per-cycle comparison of every output against the transaction model.
  always @(negedge clk) begin : cmp
    int   rel;
    logic mreq_e, done_e;
    if (!in_rst) begin
      rel    = cyc - t_acc;
      mreq_e = !e_chkflt && rel >= 2 && rel < 2 + mem_n;
      done_e = (rel == done_rel);
      check("req_ready", bus.req_ready, !(rel >= 1 && rel <= done_rel));
      check("mem_req", bus.mem_req, mreq_e);
      if (mreq_e) begin
        check("mem_we", bus.mem_we, !e_load);
        check("mem_addr", bus.mem_addr, e_maddr);
        if (!e_load) begin
          check("mem_wdata", bus.mem_wdata, e_mwdata);
          check("mem_wstrb", bus.mem_wstrb, e_mstrb);
        end
      end
      if (bus.mem_req) obs_mreq_n++;
      if (bus.mem_req && bus.mem_ack) begin
        obs_maddr = bus.mem_addr; obs_mwdata = bus.mem_wdata;
        obs_mstrb = bus.mem_wstrb; obs_we = bus.mem_we;
      end
      check("done", bus.done, done_e);
      check("fault", bus.fault, done_e && e_cause != 2'b00);
      check("fault_cause", bus.fault_cause, done_e ? e_cause : 2'b00);
      check("wb_valid", bus.wb_valid, done_e && e_wb);
      if (done_e && e_wb) begin
        held_rd = e_rd; held_data = e_wbdata;
      end
      check("wb_rd", bus.wb_rd, held_rd);
      check("wb_data", bus.wb_data, held_data);
      if (bus.done) begin
        obs_cause = bus.fault_cause; obs_done_rel = rel;
      end
      obs_wbdata = bus.wb_data;
    end
  end

  // Issue one request; d = ack delay in MEM cycles (d >= TO means never ack).
  task automatic run(input logic ld, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [4:0] rd, input logic key, input int d,
                     input logic [31:0] rdata, input int abort_rel = 0);
    int guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) check("ready_wait_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b1; bus.req_load = ld; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wd; bus.req_rd = rd; bus.key_access = key;
    e_cause  = m_cause(size, addr, key);
    e_chkflt = (e_cause != 2'b00);
    if (e_chkflt) begin
      mem_n = 0; done_rel = 2;
    end else if (d < TO) begin
      mem_n = d + 1; done_rel = 3 + d;
    end else begin
      mem_n = TO; done_rel = 2 + TO; e_cause = 2'b11;
    end
    e_load = ld; e_rd = rd;
    e_wb = ld && (rd != 5'd0) && (e_cause == 2'b00);
    e_wbdata = m_load(size, uns, addr, rdata);
    e_maddr = addr & ~32'h3;
    e_mstrb = m_strb(size, addr);
    e_mwdata = m_wdata(size, wd);
    obs_mreq_n = 0; obs_done_rel = -1; obs_cause = 2'b00;
    t_acc = cyc;
    for (int k = 1; k <= done_rel; k++) begin
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_rd = 5'($urandom);
      bus.req_size = 2'($urandom); bus.req_load = 1'($urandom); bus.key_access = 1'($urandom);
      bus.mem_ack = !e_chkflt && (d < TO) && (k == 2 + d);
      bus.mem_rdata = bus.mem_ack ? rdata : $urandom;
      if (abort_rel != 0 && k == abort_rel) begin
        bus.mem_ack = 1'b0;
        reset = 1'b1; in_rst = 1'b1;
        #1;
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_req_ready", bus.req_ready, 1'b1);
        return;
      end
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_load = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0; bus.key_access = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    @(posedge clk); #1;
    check("reset_req_ready", bus.req_ready, 1'b1);
    check("reset_mem_req", bus.mem_req, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_wb_data", bus.wb_data, 32'h0);
    check("reset_fault_cause", bus.fault_cause, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0; in_rst = 1'b0;
    @(posedge clk); #1;

    run(1'b1, SZ_WORD, 1'b0, 32'h100, 32'h0, 5'd5, 1'b0, 0, 32'hDEADBEEF);
    check("t1_wb_data", obs_wbdata, 32'hDEADBEEF);
    check("t1_wb_rd", bus.wb_rd, 5'd5);
    check("t1_latency", obs_done_rel, 3);

    run(1'b1, SZ_BYTE, 1'b0, 32'h103, 32'h0, 5'd6, 1'b0, 0, 32'h80123456);
    check("lb_signed", obs_wbdata, 32'hFFFFFF80);
    run(1'b1, SZ_BYTE, 1'b1, 32'h103, 32'h0, 5'd6, 1'b0, 1, 32'h80123456);
    check("lbu", obs_wbdata, 32'h00000080);

    run(1'b0, SZ_HALF, 1'b0, 32'h202, 32'h1234ABCD, 5'd9, 1'b0, 1, 32'h0);
    check("sh_we", obs_we, 1'b1);
    check("sh_addr", obs_maddr, 32'h200);
    check("sh_strb", obs_mstrb, 4'b1100);
    check("sh_wdata", obs_mwdata, 32'hABCDABCD);
    check("sh_wb_hold", obs_wbdata, 32'h00000080);

    run(1'b0, SZ_BYTE, 1'b0, 32'h1, 32'hFFFFFF5A, 5'd0, 1'b0, 0, 32'h0);
    check("sb_strb", obs_mstrb, 4'b0010);
    check("sb_wdata", obs_mwdata, 32'h5A5A5A5A);

    run(1'b1, SZ_WORD, 1'b0, 32'hF004, 32'h0, 5'd7, 1'b0, 0, 32'h0);
    check("sec_cause", obs_cause, 2'b10);
    check("sec_latency", obs_done_rel, 2);
    check("sec_no_mem", obs_mreq_n, 0);
    run(1'b1, SZ_WORD, 1'b0, 32'hF004, 32'h0, 5'd7, 1'b1, 2, 32'h11223344);
    check("key_ok_cause", obs_cause, 2'b00);
    check("key_ok_data", obs_wbdata, 32'h11223344);

    run(1'b1, SZ_WORD, 1'b0, 32'h102, 32'h0, 5'd3, 1'b0, 0, 32'h0);
    check("misalign_cause", obs_cause, 2'b01);
    run(1'b1, SZ_HALF, 1'b0, 32'hF001, 32'h0, 5'd3, 1'b0, 0, 32'h0);
    check("misalign_over_sec", obs_cause, 2'b01);
    run(1'b0, SZ_ILL, 1'b0, 32'h400, 32'h0, 5'd0, 1'b1, 0, 32'h0);
    check("illegal_size", obs_cause, 2'b01);

    run(1'b1, SZ_WORD, 1'b0, 32'h100, 32'h0, 5'd4, 1'b0, 255, 32'h0);
    check("timeout_cause", obs_cause, 2'b11);
    check("timeout_mreq_cycles", obs_mreq_n, 16);
    check("timeout_latency", obs_done_rel, 18);
    run(1'b1, SZ_WORD, 1'b0, 32'h104, 32'h0, 5'd4, 1'b0, TO - 1, 32'hCAFEF00D);
    check("ack_at_limit_cause", obs_cause, 2'b00);
    check("ack_at_limit_data", obs_wbdata, 32'hCAFEF00D);

    run(1'b1, SZ_HALF, 1'b0, 32'h302, 32'h0, 5'd8, 1'b0, 0, 32'h80011234);
    check("lh_signed", obs_wbdata, 32'hFFFF8001);
    run(1'b1, SZ_HALF, 1'b1, 32'h300, 32'h0, 5'd8, 1'b0, 0, 32'h1234F00D);
    check("lhu", obs_wbdata, 32'h0000F00D);
    run(1'b1, SZ_WORD, 1'b0, 32'h500, 32'h0, 5'd0, 1'b0, 0, 32'h55555555);
    check("rd0_hold", obs_wbdata, 32'h0000F00D);

    run(1'b1, SZ_WORD, 1'b0, 32'hEFFC, 32'h0, 5'd1, 1'b0, 0, 32'h0A0B0C0D);
    check("below_sec", obs_cause, 2'b00);
    run(1'b1, SZ_WORD, 1'b0, 32'hFFFC, 32'h0, 5'd1, 1'b0, 0, 32'h0);
    check("sec_top", obs_cause, 2'b10);
    run(1'b1, SZ_WORD, 1'b0, 32'h10000, 32'h0, 5'd1, 1'b0, 0, 32'h01020304);
    check("above_sec", obs_cause, 2'b00);

    run(1'b1, SZ_WORD, 1'b0, 32'h100, 32'h0, 5'd3, 1'b0, 255, 32'h0, 4);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_mem_req", bus.mem_req, 1'b0);
    check("rst_wb_data", bus.wb_data, 32'h0);
    reset = 1'b0;
    t_acc = cyc - 100000; done_rel = 0; mem_n = 0;
    held_rd = '0; held_data = '0;
    in_rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", bus.req_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    run(1'b1, SZ_WORD, 1'b0, 32'h600, 32'h0, 5'd2, 1'b0, 0, 32'h600DF00D);
    check("post_rst_data", obs_wbdata, 32'h600DF00D);
    check("post_rst_latency", obs_done_rel, 3);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
